// File: rtl/memory.sv
// Simple dual-port RAM: one write port, one registered read-first read port.
// Storage has no reset so it maps onto an iCE40 block RAM; reset clears only r_data.
module memory #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  w_en,
    input  logic                  r_en,
    input  logic [ADDR_WIDTH-1:0] w_addr,
    input  logic [ADDR_WIDTH-1:0] r_addr,
    input  logic [DATA_WIDTH-1:0] w_data,
    output logic [DATA_WIDTH-1:0] r_data
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    // NOTE: the array is never reset; the declaration initialiser becomes the
    // block RAM's configuration contents and keeps it inferable as a BRAM.
    logic [DATA_WIDTH-1:0] mem_q [DEPTH] = '{default: '0};
    logic [DATA_WIDTH-1:0] r_data_q;

    // NOTE: non-blocking assignments make a same-address read see the old word.
    always_ff @(posedge clk) begin
        if (!rst && w_en) begin
            mem_q[w_addr] <= w_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_q <= '0;
        end else if (r_en) begin
            r_data_q <= mem_q[r_addr];
        end
    end

    assign r_data = r_data_q;

endmodule

// File: tb/tb_memory.sv
// Self-checking bench for memory: a reference model predicts each edge's r_data,
// which is queued at drive time and popped and asserted one time step after the edge.
module tb_memory;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          w_en;
    logic          r_en;
    logic [AW-1:0] w_addr;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] w_data;
    logic [DW-1:0] r_data;

    logic [DW-1:0] mdl [DEPTH];
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] last_exp;
    int            n_tests = 0;
    int            n_fail  = 0;

    always #5 clk = ~clk;

    memory #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .w_en  (w_en),
        .r_en  (r_en),
        .w_addr(w_addr),
        .r_addr(r_addr),
        .w_data(w_data),
        .r_data(r_data)
    );

    task automatic step(input logic rs, input logic we, input logic [AW-1:0] wa,
                        input logic [DW-1:0] wd, input logic re,
                        input logic [AW-1:0] ra, input string tag);
        logic [DW-1:0] exp_v;
        logic [DW-1:0] got_exp;
        if (rs)      exp_v = '0;
        else if (re) exp_v = mdl[ra];
        else         exp_v = last_exp;
        exp_q.push_back(exp_v);
        rst    = rs;
        w_en   = we;
        w_addr = wa;
        w_data = wd;
        r_en   = re;
        r_addr = ra;
        @(posedge clk);
        #1;
        if (!rs && we) mdl[wa] = wd;
        last_exp = exp_v;
        got_exp = exp_q.pop_front();
        n_tests++;
        assert (r_data === got_exp) else begin
            n_fail++;
            $error("FAIL %s: r_data=%h expected=%h", tag, r_data, got_exp);
        end
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input string tag);
        step(1'b0, 1'b1, a, d, 1'b0, 'x, tag);
    endtask

    task automatic rd(input logic [AW-1:0] a, input string tag);
        step(1'b0, 1'b0, 'x, 'x, 1'b1, a, tag);
    endtask

    task automatic idle(input string tag);
        step(1'b0, 1'b0, 'x, 'x, 1'b0, 'x, tag);
    endtask

    task automatic check_const(input logic [DW-1:0] want, input string tag);
        n_tests++;
        assert (r_data === want) else begin
            n_fail++;
            $error("FAIL %s: r_data=%h expected=%h", tag, r_data, want);
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
        last_exp = '0;
        rst = 1'b1; w_en = 1'b0; r_en = 1'b0;
        w_addr = 'x; r_addr = 'x; w_data = 'x;

        // Reset clears r_data and suppresses a write and a read issued under it
        step(1'b1, 1'b0, 'x, 'x, 1'b0, 'x, "reset");
        step(1'b1, 1'b1, 4'h9, 8'hEE, 1'b1, 4'h9, "reset_suppress");

        // Cold read and proof that the suppressed write never landed
        rd(4'hF, "cold_read");
        check_const(8'h00, "cold_read_const");
        rd(4'h9, "rst_no_write");

        // Write then read, then hold with X on idle inputs
        wr(4'hF, 8'hA5, "wr_f");
        rd(4'hF, "rd_f");
        check_const(8'hA5, "rd_f_const");
        idle("hold_f_1");
        idle("hold_f_2");
        check_const(8'hA5, "hold_f_const");

        // Read-first collision
        wr(4'h3, 8'h11, "wr_3");
        step(1'b0, 1'b1, 4'h3, 8'h22, 1'b1, 4'h3, "collide_old");
        check_const(8'h11, "collide_old_const");
        rd(4'h3, "collide_new");
        check_const(8'h22, "collide_new_const");

        // Simultaneous write and read at different addresses
        step(1'b0, 1'b1, 4'h4, 8'h44, 1'b1, 4'hF, "diff_addr_rd");
        rd(4'h4, "diff_addr_wr");

        // Reset mid-operation keeps storage and resumes immediately
        wr(4'h7, 8'h5A, "wr_7");
        rd(4'h7, "rd_7");
        step(1'b1, 1'b1, 4'h7, 8'hFF, 1'b1, 4'h7, "mid_reset");
        check_const(8'h00, "mid_reset_const");
        rd(4'h7, "rd_7_after_rst");
        check_const(8'h5A, "rd_7_after_rst_const");

        // Full sweep with a hold cycle between reads
        for (int i = 0; i < DEPTH; i++) begin
            wr(AW'(i), DW'(i) ^ 8'hC3, $sformatf("sweep_wr_%0d", i));
        end
        for (int i = 0; i < DEPTH; i++) begin
            rd(AW'(i), $sformatf("sweep_rd_%0d", i));
            check_const(DW'(i) ^ 8'hC3, $sformatf("sweep_const_%0d", i));
            idle($sformatf("sweep_hold_%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/memory.md
MEMORY -- requirements
Module: memory

Interface
REQ-001 The block SHALL have exactly one clock and SHALL use a synchronous, active-high reset.
REQ-002 Parameter DATA_WIDTH, default 8, SHALL set the width of one storage word.
REQ-003 Parameter ADDR_WIDTH, default 4, SHALL set the address width; depth SHALL be 2^ADDR_WIDTH (16 words at default).
REQ-004 Port clk, input, 1 bit: the single clock; all state changes SHALL occur on its rising edge.
REQ-005 Port rst, input, 1 bit: synchronous active-high reset.
REQ-006 Port w_en, input, 1 bit: write enable.
REQ-007 Port r_en, input, 1 bit: read enable.
REQ-008 Port w_addr, input, ADDR_WIDTH bits: write address.
REQ-009 Port r_addr, input, ADDR_WIDTH bits: read address.
REQ-010 Port w_data, input, DATA_WIDTH bits: write data.
REQ-011 Port r_data, output, DATA_WIDTH bits: registered read data.

Function
REQ-012 The block SHALL be a simple dual-port RAM: one write port and one read port, independently addressed, sharing clk.
REQ-013 Storage SHALL hold 2^ADDR_WIDTH words of DATA_WIDTH bits, all initialised to 0 at power-up/configuration.
REQ-014 On a rising edge with rst=0 and w_en=1, mem[w_addr] SHALL be loaded with w_data.
REQ-015 On a rising edge with w_en=0, no storage location SHALL change.
REQ-016 On a rising edge with rst=0 and r_en=1, r_data SHALL be loaded with mem[r_addr]; read latency SHALL be exactly one clock edge.
REQ-017 On a rising edge with r_en=0, r_data SHALL hold its previous value.
REQ-018 Read and write in the same cycle at different addresses SHALL both complete with no interaction.
REQ-019 Read and write in the same cycle at the same address SHALL be read-first: r_data SHALL receive the old stored word; the new word SHALL be visible from the next read onward.
REQ-020 X/undefined values on w_addr, w_data or r_addr SHALL have no effect while the corresponding enable is 0.
REQ-021 Addresses SHALL cover the full range 0 to 2^ADDR_WIDTH-1 with no aliasing and no out-of-range case.
REQ-022 The storage array SHALL be inferable as an iCE40 block RAM: no reset on the array, and a single synchronous read register.

Reset
REQ-023 On a rising edge with rst=1, r_data SHALL be cleared to 0.
REQ-024 While rst=1, writes and reads SHALL be suppressed regardless of w_en and r_en.
REQ-025 Reset SHALL NOT clear storage contents; words written before reset SHALL be readable after rst is released.
REQ-026 The first edge with rst=0 SHALL resume normal operation with no additional latency.

Verification
REQ-027 Cold read: after power-up, r_en=1 with r_addr=0x0F for one edge -> r_data=0x00 after that edge.
REQ-028 Write then read: w_en=1, w_addr=0x0F, w_data=0xA5 for one edge; then r_en=1, r_addr=0x0F -> r_data=0xA5 one edge later; r_data SHALL stay 0xA5 after r_en drops.
REQ-029 Read-first collision: mem[0x3]=0x11; in one cycle write 0x22 to 0x3 and read 0x3 -> r_data=0x11; the next read of 0x3 -> r_data=0x22.
REQ-030 Reset mid-operation: write 0x5A to 0x7, read it (r_data=0x5A), assert rst for one edge with w_en=1, w_addr=0x7, w_data=0xFF -> r_data=0x00; after release, read 0x7 -> r_data=0x5A.
REQ-031 Full sweep: write address i with value (i XOR 0xC3) for i=0..15, then read all 16 -> every read returns its written value; an r_en=0 cycle between reads holds r_data.
